ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, 33-cycle shift-add multiplier,
// and the EX/MEM pipeline register. ex_busy stalls the upstream stages while a MUL runs.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ALU_MUX1,
  input  logic [1:0]  ALU_MUX2,
  input  logic [31:0] ID_EX_ReadData1,
  input  logic [31:0] ID_EX_ReadData2,
  input  logic [31:0] ID_EX_Imm,
  input  logic [3:0]  ID_EX_ALUOp,
  input  logic        ID_EX_ALUSrc,
  input  logic [4:0]  ID_EX_RegRt,
  input  logic [4:0]  ID_EX_RegRd,
  input  logic        ID_EX_RegDst,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MemWrite,
  input  logic        ID_EX_MemtoReg,
  input  logic        ID_EX_Valid,
  input  logic [31:0] MEM_WB_WriteData,
  input  logic        ex_flush,
  output logic [31:0] EX_MEM_ALUResult,
  output logic [31:0] EX_MEM_WriteData,
  output logic [4:0]  EX_MEM_RegRd,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_MemWrite,
  output logic        EX_MEM_MemtoReg,
  output logic        EX_MEM_Zero,
  output logic        ex_busy,
  output logic [1:0]  o_dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic [31:0] r_mul_store;
  logic [4:0]  r_mul_dest;
  logic [3:0]  r_mul_ctl;

  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;
  logic [4:0]  w_dest;
  logic [3:0]  w_ctl;
  logic        w_is_mul;
  logic        w_mul_start;
  logic        w_done;
  logic        w_load;
  logic [31:0] w_nxt_result;
  logic [31:0] w_nxt_store;
  logic [4:0]  w_nxt_dest;
  logic [3:0]  w_nxt_ctl;

  // Select code 11 is unused and falls back to the register-file value.
  always_comb begin
    w_op_a = ID_EX_ReadData1;
    case (ALU_MUX1)
      2'b01:   w_op_a = EX_MEM_ALUResult;
      2'b10:   w_op_a = MEM_WB_WriteData;
      default: w_op_a = ID_EX_ReadData1;
    endcase
  end

  always_comb begin
    w_fwd_b = ID_EX_ReadData2;
    case (ALU_MUX2)
      2'b01:   w_fwd_b = EX_MEM_ALUResult;
      2'b10:   w_fwd_b = MEM_WB_WriteData;
      default: w_fwd_b = ID_EX_ReadData2;
    endcase
  end

  assign w_op_b = ID_EX_ALUSrc ? ID_EX_Imm : w_fwd_b;
  assign w_dest = ID_EX_RegDst ? ID_EX_RegRd : ID_EX_RegRt;
  assign w_ctl  = {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg};

  always_comb begin
    w_alu_result = '0;
    case (ID_EX_ALUOp)
      OP_AND:  w_alu_result = w_op_a & w_op_b;
      OP_OR:   w_alu_result = w_op_a | w_op_b;
      OP_ADD:  w_alu_result = w_op_a + w_op_b;
      OP_SUB:  w_alu_result = w_op_a - w_op_b;
      OP_SLT:  w_alu_result = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
      OP_NOR:  w_alu_result = ~(w_op_a | w_op_b);
      default: w_alu_result = '0;
    endcase
  end

  assign w_is_mul    = (ID_EX_ALUOp == OP_MUL);
  assign w_mul_start = (r_state == S_IDLE) && ID_EX_Valid && w_is_mul;
  assign w_done      = (r_state == S_DONE);
  assign ex_busy     = rst_n && !ex_flush && ((r_state == S_BUSY) || w_mul_start);
  assign o_dbg_state = r_state;

  // EX/MEM loads either a finished single-cycle op or the completed product.
  assign w_load = !ex_flush &&
                  (w_done || ((r_state == S_IDLE) && ID_EX_Valid && !w_is_mul));
  assign w_nxt_result = w_done ? r_acc       : w_alu_result;
  assign w_nxt_store  = w_done ? r_mul_store : w_fwd_b;
  assign w_nxt_dest   = w_done ? r_mul_dest  : w_dest;
  assign w_nxt_ctl    = w_done ? r_mul_ctl   : w_ctl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_store <= '0;
      r_mul_dest  <= '0;
      r_mul_ctl   <= '0;
    end else if (ex_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mul_a     <= w_op_a;
            r_mul_b     <= w_op_b;
            r_mul_store <= w_fwd_b;
            r_mul_dest  <= w_dest;
            r_mul_ctl   <= w_ctl;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Low 32 bits of the product are identical for signed and unsigned operands.
          r_acc   <= r_acc + (r_mul_b[0] ? r_mul_a : 32'd0);
          r_mul_a <= {r_mul_a[30:0], 1'b0};
          r_mul_b <= {1'b0, r_mul_b[31:1]};
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      EX_MEM_ALUResult <= '0;
      EX_MEM_WriteData <= '0;
      EX_MEM_RegRd     <= '0;
      EX_MEM_RegWrite  <= 1'b0;
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_MemtoReg  <= 1'b0;
      EX_MEM_Zero      <= 1'b0;
    end else if (w_load) begin
      EX_MEM_ALUResult <= w_nxt_result;
      EX_MEM_WriteData <= w_nxt_store;
      EX_MEM_RegRd     <= w_nxt_dest;
      {EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg} <= w_nxt_ctl;
      EX_MEM_Zero      <= (w_nxt_result == 32'd0);
    end else begin
      // Bubble: control and destination cleared, data registers keep their values.
      EX_MEM_RegRd    <= '0;
      EX_MEM_RegWrite <= 1'b0;
      EX_MEM_MemRead  <= 1'b0;
      EX_MEM_MemWrite <= 1'b0;
      EX_MEM_MemtoReg <= 1'b0;
      EX_MEM_Zero     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a cycle-count based behavioural model.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ALU_MUX1, ALU_MUX2;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
  logic [3:0]  ID_EX_ALUOp;
  logic        ID_EX_ALUSrc;
  logic [4:0]  ID_EX_RegRt, ID_EX_RegRd;
  logic        ID_EX_RegDst, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic        ID_EX_Valid;
  logic [31:0] MEM_WB_WriteData;
  logic        ex_flush;
  logic [31:0] EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [4:0]  EX_MEM_RegRd;
  logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg, EX_MEM_Zero;
  logic        ex_busy;
  logic [1:0]  o_dbg_state;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ALU_MUX1(ALU_MUX1), .ALU_MUX2(ALU_MUX2),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_RegRt(ID_EX_RegRt), .ID_EX_RegRd(ID_EX_RegRd), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_Valid(ID_EX_Valid), .MEM_WB_WriteData(MEM_WB_WriteData), .ex_flush(ex_flush),
    .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
    .EX_MEM_RegRd(EX_MEM_RegRd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_Zero(EX_MEM_Zero),
    .ex_busy(ex_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;
  logic last_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: m_left = -1 idle, >0 busy cycles still owed, 0 = product due now.
  logic [31:0] m_alu, m_wd, m_prod, m_pstore;
  logic [4:0]  m_rd, m_pdest;
  logic [3:0]  m_ctl, m_pctl;
  logic        m_zero;
  int          m_left = -1;

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return m_alu;
    if (sel == 2'b10) return MEM_WB_WriteData;
    return rf;
  endfunction

  function automatic logic [31:0] golden(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_busy();
    if (!rst_n || ex_flush) return 1'b0;
    if (m_left > 0) return 1'b1;
    return (m_left < 0) && ID_EX_Valid && (ID_EX_ALUOp == 4'b1000);
  endfunction

  task automatic m_bubble();
    m_rd = '0; m_ctl = '0; m_zero = 1'b0;
  endtask

  task automatic m_load(input logic [31:0] r, input logic [31:0] s, input logic [4:0] d,
                        input logic [3:0] c);
    m_alu = r; m_wd = s; m_rd = d; m_ctl = c; m_zero = (r == 0);
  endtask

  task automatic model_step();
    logic [31:0] a, bf, b;
    logic [4:0]  d;
    logic [3:0]  c;
    a  = fwd(ALU_MUX1, ID_EX_ReadData1);
    bf = fwd(ALU_MUX2, ID_EX_ReadData2);
    b  = ID_EX_ALUSrc ? ID_EX_Imm : bf;
    d  = ID_EX_RegDst ? ID_EX_RegRd : ID_EX_RegRt;
    c  = {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg};
    if (!rst_n) begin
      m_alu = '0; m_wd = '0; m_bubble(); m_left = -1;
    end else if (ex_flush) begin
      m_bubble(); m_left = -1;
    end else if (m_left == 0) begin
      m_load(m_prod, m_pstore, m_pdest, m_pctl); m_left = -1;
    end else if (m_left > 0) begin
      m_bubble(); m_left--;
    end else if (ID_EX_Valid && ID_EX_ALUOp == 4'b1000) begin
      m_bubble();
      m_prod = a * b; m_pstore = bf; m_pdest = d; m_pctl = c;
      m_left = 32;
    end else if (ID_EX_Valid) begin
      m_load(golden(ID_EX_ALUOp, a, b), bf, d, c);
    end else begin
      m_bubble();
    end
  endtask

  // One clock: inputs already driven; check busy, advance model, check registered outputs.
  task automatic tick();
    #1;
    last_busy = ex_busy;
    chk("ex_busy", {31'd0, ex_busy}, {31'd0, model_busy()});
    model_step();
    @(negedge clk);
    chk("alu_result", EX_MEM_ALUResult, m_alu);
    chk("write_data", EX_MEM_WriteData, m_wd);
    chk("reg_rd", {27'd0, EX_MEM_RegRd}, {27'd0, m_rd});
    chk("ctl", {28'd0, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg},
        {28'd0, m_ctl});
    chk("zero", {31'd0, EX_MEM_Zero}, {31'd0, m_zero});
  endtask

  // Driver tasks
  task automatic drive(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic src, input logic [1:0] m1,
                       input logic [1:0] m2);
    ID_EX_ALUOp = op; ID_EX_ReadData1 = rd1; ID_EX_ReadData2 = rd2; ID_EX_Imm = imm;
    ID_EX_ALUSrc = src; ALU_MUX1 = m1; ALU_MUX2 = m2;
    ID_EX_RegRt = 5'd3; ID_EX_RegRd = 5'd9; ID_EX_RegDst = 1'b1;
    ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_MemWrite = 1'b0; ID_EX_MemtoReg = 1'b0;
    ID_EX_Valid = 1'b1; ex_flush = 1'b0; rst_n = 1'b1;
  endtask

  task automatic drive_random();
    logic [3:0] ops [7];
    int pick;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000};
    pick = $urandom_range(0, 9);
    ID_EX_ALUOp      = (pick < 7) ? ops[pick] : 4'($urandom_range(0, 15));
    ID_EX_ReadData1  = $urandom;
    ID_EX_ReadData2  = ($urandom_range(0, 3) == 0) ? ID_EX_ReadData1 : $urandom;
    ID_EX_Imm        = $urandom;
    ID_EX_ALUSrc     = 1'($urandom_range(0, 1));
    ALU_MUX1         = 2'($urandom_range(0, 3));
    ALU_MUX2         = 2'($urandom_range(0, 3));
    MEM_WB_WriteData = $urandom;
    ID_EX_RegRt      = 5'($urandom_range(0, 31));
    ID_EX_RegRd      = 5'($urandom_range(0, 31));
    ID_EX_RegDst     = 1'($urandom_range(0, 1));
    {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg} = 4'($urandom_range(0, 15));
    ID_EX_Valid      = ($urandom_range(0, 99) < 85);
    ex_flush         = ($urandom_range(0, 99) < 3);
    rst_n            = ($urandom_range(0, 199) != 0);
  endtask

  int busy_cnt;

  initial begin
    drive(4'b0000, '0, '0, '0, 1'b0, 2'b00, 2'b00);
    MEM_WB_WriteData = '0;
    ID_EX_Valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_result", EX_MEM_ALUResult, 32'd0);
    chk("reset_regwrite", {31'd0, EX_MEM_RegWrite}, 32'd0);

    // ADD wraps: 5 + 0xFFFFFFFF = 4
    drive(4'b0010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2'b00, 2'b00);
    tick();
    chk("add_wrap", EX_MEM_ALUResult, 32'd4);
    chk("add_zero", {31'd0, EX_MEM_Zero}, 32'd0);

    // Forwarded SUB: 7 (EX/MEM) - 7 (MEM/WB) = 0
    drive(4'b0010, 32'd3, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00);
    tick();
    drive(4'b0110, 32'd100, 32'd200, 32'd0, 1'b0, 2'b01, 2'b10);
    MEM_WB_WriteData = 32'd7;
    tick();
    chk("sub_fwd", EX_MEM_ALUResult, 32'd0);
    chk("sub_zero", {31'd0, EX_MEM_Zero}, 32'd1);

    // SLT signed with select code 11 taking the register-file value
    drive(4'b0111, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 2'b11, 2'b11);
    MEM_WB_WriteData = 32'h8000_0000;
    tick();
    chk("slt_signed", EX_MEM_ALUResult, 32'd1);

    // MUL -3 * 6 with operands scrambled during BUSY
    drive(4'b1000, 32'hFFFF_FFFD, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!last_busy) break;
      busy_cnt++;
      ID_EX_ReadData1 = $urandom;
      ID_EX_ReadData2 = $urandom;
      ALU_MUX1 = 2'($urandom_range(0, 3));
      ID_EX_RegRd = 5'($urandom_range(0, 31));
    end
    chk("mul_busy_cycles", busy_cnt, 32'd33);
    chk("mul_product", EX_MEM_ALUResult, 32'hFFFF_FFEE);
    chk("mul_regwrite", {31'd0, EX_MEM_RegWrite}, 32'd1);
    chk("mul_dest", {27'd0, EX_MEM_RegRd}, 32'd9);

    // Flush at BUSY cycle 10, then ADD completes in one cycle
    drive(4'b1000, 32'd1234, 32'd5678, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    for (int i = 0; i < 10; i++) tick();
    ex_flush = 1'b1;
    tick();
    chk("flush_busy", {31'd0, last_busy}, 32'd0);
    chk("flush_regwrite", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("flush_idle", {30'd0, o_dbg_state}, 32'd0);
    drive(4'b0010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2'b00, 2'b00);
    tick();
    chk("post_flush_add", EX_MEM_ALUResult, 32'd4);
    chk("post_flush_rw", {31'd0, EX_MEM_RegWrite}, 32'd1);

    // Reset mid-multiply
    drive(4'b1000, 32'd77, 32'd88, 32'd0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_busy", {31'd0, last_busy}, 32'd0);
    chk("rst_result", EX_MEM_ALUResult, 32'd0);
    chk("rst_wdata", EX_MEM_WriteData, 32'd0);
    chk("rst_rd", {27'd0, EX_MEM_RegRd}, 32'd0);
    rst_n = 1'b1;
    ID_EX_Valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_invalid_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rst_invalid_busy", {31'd0, last_busy}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
